// File: rtl/vram_line_port.sv
//------------------------------------------------------------------------------
// vram_line_port : owns the single VRAM line port, arbitrating scanout reads
//                  against writer read-modify-write slots.   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vram_line_port #(
   parameter int LINE_W    = 640,
   parameter int ADDR_W    = 9,
   parameter int NUM_LINES = 480,
   parameter int RAM_LAT   = 1,
   parameter int TURN_HIGH = 2,
   parameter int SETTLE    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] vram_addr,
   input  logic [LINE_W-1:0] vram_out,
   input  logic              activate_write,
   output logic [LINE_W-1:0] vram_in,
   output logic              vram_turn,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic [LINE_W-1:0] scan_line,
   output logic              scan_valid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [LINE_W-1:0] ram_wdata,
   input  logic [LINE_W-1:0] ram_rdata,
   output logic              err_oor,
   output logic              err_scan_ovr,
   output logic [15:0]       slot_count
);

   localparam int               CNT_W      = 8;
   localparam logic [CNT_W-1:0] LAT_END    = CNT_W'(RAM_LAT);
   localparam logic [CNT_W-1:0] TURN_END   = CNT_W'(TURN_HIGH - 1);
   localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
   localparam logic [ADDR_W:0]  LINES      = (ADDR_W+1)'(NUM_LINES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SCAN      = 3'd1,
      S_WR_RD     = 3'd2,
      S_WR_TURN   = 3'd3,
      S_WR_SETTLE = 3'd4,
      S_WR_COMMIT = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nx;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] act_addr;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend;
   logic              rd_oor;
   logic              act_oor;
   logic              wr_oor;
   logic              scan_go;
   logic              lat_done;

   assign rd_oor   = ({1'b0, rd_addr} >= LINES);
   assign act_oor  = ({1'b0, act_addr} >= LINES);
   assign wr_oor   = ({1'b0, vram_addr} >= LINES);
   assign scan_go  = pend | scan_req;
   assign lat_done = (cnt == LAT_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Out-of-range lines never reach the BRAM: the address bus is parked at 0.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt + 1'b1;
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      case (state)
         S_IDLE: begin
            cnt_nx   = '0;
            state_nx = scan_go ? S_SCAN : S_WR_RD;
         end
         S_SCAN: begin
            if (!act_oor) ram_addr = act_addr;
            if (lat_done) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end
         end
         S_WR_RD: begin
            if (!rd_oor) ram_addr = rd_addr;
            if (lat_done) begin
               state_nx = S_WR_TURN;
               cnt_nx   = '0;
            end
         end
         S_WR_TURN: begin
            if (cnt == TURN_END) begin
               state_nx = S_WR_SETTLE;
               cnt_nx   = '0;
            end
         end
         S_WR_SETTLE: begin
            if (cnt == SETTLE_END) begin
               state_nx = S_WR_COMMIT;
               cnt_nx   = '0;
            end
         end
         S_WR_COMMIT: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            if (activate_write && !wr_oor) begin
               ram_we    = 1'b1;
               ram_addr  = vram_addr;
               ram_wdata = vram_out;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vram_in      <= '0;
         vram_turn    <= 1'b0;
         scan_line    <= '0;
         scan_valid   <= 1'b0;
         err_oor      <= 1'b0;
         err_scan_ovr <= 1'b0;
         slot_count   <= '0;
         rd_addr      <= '0;
         act_addr     <= '0;
         pend_addr    <= '0;
         pend         <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         // Registered from the next state so the writer strobe never glitches.
         vram_turn  <= (state_nx == S_WR_TURN);

         if (scan_req) begin
            pend_addr <= scan_addr;
            if (pend) err_scan_ovr <= 1'b1;
         end

         // IDLE consumes any pending (or just-arriving) scan; elsewhere it queues.
         if (state == S_IDLE) begin
            pend <= 1'b0;
            if (scan_go) act_addr <= scan_req ? scan_addr : pend_addr;
            else         rd_addr  <= vram_addr;
         end else if (scan_req) begin
            pend <= 1'b1;
         end

         if (state == S_SCAN && lat_done) begin
            scan_valid <= 1'b1;
            scan_line  <= act_oor ? '0 : ram_rdata;
            if (act_oor) err_oor <= 1'b1;
         end

         if (state == S_WR_RD && lat_done) begin
            vram_in <= rd_oor ? '0 : ram_rdata;
            if (rd_oor) err_oor <= 1'b1;
         end

         if (state == S_WR_COMMIT) begin
            slot_count <= slot_count + 16'd1;
            if (activate_write && wr_oor) err_oor <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_line_port.sv
//------------------------------------------------------------------------------
// tb_vram_line_port : directed + randomized bench with a line-level VRAM model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vram_line_port;

   localparam int LINE_W    = 640;
   localparam int ADDR_W    = 9;
   localparam int NUM_LINES = 480;
   localparam int RAM_LAT   = 1;
   localparam int TURN_HIGH = 2;
   localparam int SETTLE    = 1;
   localparam int NW        = LINE_W / 32;

   typedef logic [LINE_W-1:0] line_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [ADDR_W-1:0] vram_addr = '0;
   line_t             vram_out = '0;
   logic              activate_write = 1'b0;
   line_t             vram_in;
   logic              vram_turn;
   logic              scan_req = 1'b0;
   logic [ADDR_W-1:0] scan_addr = '0;
   line_t             scan_line;
   logic              scan_valid;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   line_t             ram_wdata;
   line_t             ram_rdata;
   logic              err_oor;
   logic              err_scan_ovr;
   logic [15:0]       slot_count;

   always #5 clk = ~clk;

   vram_line_port #(
      .LINE_W(LINE_W), .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES),
      .RAM_LAT(RAM_LAT), .TURN_HIGH(TURN_HIGH), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .vram_addr(vram_addr), .vram_out(vram_out), .activate_write(activate_write),
      .vram_in(vram_in), .vram_turn(vram_turn),
      .scan_req(scan_req), .scan_addr(scan_addr),
      .scan_line(scan_line), .scan_valid(scan_valid),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .err_oor(err_oor), .err_scan_ovr(err_scan_ovr), .slot_count(slot_count)
   );

   // Block RAM with a backdoor preload port and RAM_LAT read pipeline.
   line_t             bram  [NUM_LINES];
   line_t             rpipe [RAM_LAT];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   line_t             pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) bram[pl_addr] <= pl_data;
      else if (ram_we && ram_addr < ADDR_W'(NUM_LINES)) bram[ram_addr] <= ram_wdata;
      rpipe[0] <= (ram_addr < ADDR_W'(NUM_LINES)) ? bram[ram_addr] : '0;
      for (int i = 1; i < RAM_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[RAM_LAT-1];

   // Passive monitor: log every BRAM write and count scan strobes.
   logic [ADDR_W-1:0] wq_addr[$];
   line_t             wq_data[$];
   int                wr_total = 0;
   int                sv_total = 0;

   always @(posedge clk) begin
      if (ram_we) begin
         wq_addr.push_back(ram_addr);
         wq_data.push_back(ram_wdata);
         wr_total <= wr_total + 1;
      end
      if (scan_valid) sv_total <= sv_total + 1;
   end

   int          checks = 0;
   int          failures = 0;
   line_t       gold [NUM_LINES];
   logic [15:0] exp_slots = '0;
   bit          exp_oor = 1'b0;
   bit          exp_ovr = 1'b0;
   int          exp_scans = 0;

   task automatic chk(input string tag, input line_t obs, input line_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic line_t rand_line();
      line_t v;
      for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic line_t line_of(input logic [ADDR_W-1:0] a);
      return (a < ADDR_W'(NUM_LINES)) ? gold[a] : '0;
   endfunction

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 7) == 0)
         return ADDR_W'($urandom_range(NUM_LINES, (1 << ADDR_W) - 1));
      return ADDR_W'($urandom_range(0, NUM_LINES - 1));
   endfunction

   task automatic wait_rise(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         n++;
         if (vram_turn) ok = 1'b1;
      end
   endtask

   // One writer slot, entered at a negedge of an IDLE cycle; optional scans during it.
   task automatic do_slot(input logic [ADDR_W-1:0] a, input bit act, input line_t d,
                          input int nscan, input logic [ADDR_W-1:0] s0,
                          input logic [ADDR_W-1:0] s1);
      line_t             exp_in;
      bit                ok;
      int                n;
      int                w0;
      int                tv;
      logic [ADDR_W-1:0] sa;
      vram_addr      = a;
      activate_write = 1'b0;
      vram_out       = rand_line();
      exp_in         = line_of(a);
      w0             = wr_total;
      wait_rise(ok, n);
      chk("turn_seen", line_t'(ok), line_t'(1));
      chk("turn_delay", line_t'(n), line_t'(2 + RAM_LAT));
      chk("scan_pulses", line_t'(sv_total), line_t'(exp_scans));
      chk("vram_in", vram_in, exp_in);
      activate_write = act;
      vram_out       = d;
      if (nscan > 0) begin
         scan_addr = s0;
         scan_req  = 1'b1;
      end
      @(negedge clk);
      scan_req = 1'b0;
      chk("turn_2nd", line_t'(vram_turn), line_t'(1));
      chk("vram_in_hold", vram_in, exp_in);
      if (nscan == 2) begin
         @(negedge clk);
         chk("turn_fell", line_t'(vram_turn), line_t'(0));
         scan_addr = s1;
         scan_req  = 1'b1;
         @(negedge clk);
         scan_req = 1'b0;
         exp_ovr  = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (slot_count != exp_slots) ok = 1'b1;
         else @(negedge clk);
      end
      chk("slot_done", line_t'(ok), line_t'(1));
      exp_slots++;
      chk("slot_count", line_t'(slot_count), line_t'(exp_slots));
      if (act && a < ADDR_W'(NUM_LINES)) begin
         chk("wr_cnt", line_t'(wr_total - w0), line_t'(1));
         if (wr_total > w0) begin
            chk("wr_addr", line_t'(wq_addr[w0]), line_t'(a));
            chk("wr_data", wq_data[w0], d);
         end
         gold[a] = d;
      end else begin
         chk("wr_cnt", line_t'(wr_total - w0), line_t'(0));
      end
      if (a >= ADDR_W'(NUM_LINES)) exp_oor = 1'b1;
      if (nscan > 0) begin
         sa = (nscan == 2) ? s1 : s0;
         ok = 1'b0;
         tv = 0;
         for (int i = 0; i < 40 && !ok; i++) begin
            if (scan_valid) ok = 1'b1;
            else begin
               @(negedge clk);
               tv++;
            end
         end
         chk("scan_seen", line_t'(ok), line_t'(1));
         chk("scan_latency", line_t'(tv), line_t'(2 + RAM_LAT));
         chk("scan_line", scan_line, line_of(sa));
         if (sa >= ADDR_W'(NUM_LINES)) exp_oor = 1'b1;
         exp_scans++;
      end
      chk("err_oor", line_t'(err_oor), line_t'(exp_oor));
      chk("err_scan_ovr", line_t'(err_scan_ovr), line_t'(exp_ovr));
   endtask

   initial begin : main
      int nturn;
      int nrise;
      int first;
      int second;
      int w0;
      int n;
      bit prev;
      bit ok;
      #1 rst_n = 1'b0;

      // Preload the BRAM and the model identically; line 340 gets the AAAA pattern.
      for (int i = 0; i < NUM_LINES; i++) begin
         gold[i] = (i == 340) ? {40{16'hAAAA}} : rand_line();
         @(negedge clk);
         pl_en   = 1'b1;
         pl_addr = ADDR_W'(i);
         pl_data = gold[i];
      end
      @(negedge clk);
      pl_en = 1'b0;

      chk("rst_vram_turn", line_t'(vram_turn), '0);
      chk("rst_vram_in", vram_in, '0);
      chk("rst_scan_valid", line_t'(scan_valid), '0);
      chk("rst_scan_line", scan_line, '0);
      chk("rst_ram_we", line_t'(ram_we), '0);
      chk("rst_ram_addr", line_t'(ram_addr), '0);
      chk("rst_ram_wdata", ram_wdata, '0);
      chk("rst_err_oor", line_t'(err_oor), '0);
      chk("rst_err_ovr", line_t'(err_scan_ovr), '0);
      chk("rst_slot_count", line_t'(slot_count), '0);

      // Idle writer: three 7-cycle slots, two turn cycles each, no writes.
      rst_n  = 1'b1;
      nturn  = 0;
      nrise  = 0;
      first  = -1;
      second = -1;
      prev   = 1'b0;
      w0     = wr_total;
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (vram_turn) nturn++;
         if (vram_turn && !prev) begin
            nrise++;
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
         prev = vram_turn;
      end
      chk("idle_turn_cycles", line_t'(nturn), line_t'(6));
      chk("idle_turn_rises", line_t'(nrise), line_t'(3));
      chk("idle_first_turn", line_t'(first), line_t'(2 + RAM_LAT));
      chk("idle_period", line_t'(second - first), line_t'(7));
      chk("idle_slot_count", line_t'(slot_count), line_t'(3));
      chk("idle_no_we", line_t'(wr_total - w0), '0);
      exp_slots = 16'd3;

      // RMW of line 340, then scan it back during the next slot.
      do_slot(9'd340, 1'b1, {40{16'h5555}}, 0, '0, '0);
      do_slot(9'd7, 1'b0, rand_line(), 1, 9'd340, '0);
      chk("scan_340", scan_line, {40{16'h5555}});

      // Scan during WR_TURN, then two scans in one slot (only the later one served).
      do_slot(9'd50, 1'b0, rand_line(), 1, 9'd10, '0);
      do_slot(9'd60, 1'b1, rand_line(), 2, 9'd5, 9'd6);

      // Out-of-range writer line.
      do_slot(9'd500, 1'b1, rand_line(), 0, '0, '0);

      // Reset asserted mid-turn with a commit armed.
      vram_addr      = 9'd100;
      activate_write = 1'b0;
      w0             = wr_total;
      wait_rise(ok, n);
      chk("pre_rst_turn", line_t'(vram_turn), line_t'(1));
      activate_write = 1'b1;
      vram_out       = rand_line();
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_vram_turn", line_t'(vram_turn), '0);
      chk("midrst_vram_in", vram_in, '0);
      chk("midrst_ram_we", line_t'(ram_we), '0);
      chk("midrst_err_oor", line_t'(err_oor), '0);
      chk("midrst_err_ovr", line_t'(err_scan_ovr), '0);
      chk("midrst_slot_count", line_t'(slot_count), '0);
      chk("midrst_scan_line", scan_line, '0);
      @(negedge clk);
      @(negedge clk);
      chk("midrst_no_write", line_t'(wr_total - w0), '0);
      exp_slots = '0;
      exp_oor   = 1'b0;
      exp_ovr   = 1'b0;
      rst_n     = 1'b1;
      do_slot(9'd100, 1'b0, rand_line(), 0, '0, '0);

      // Randomized slots against the line model.
      for (int k = 0; k < 30; k++) begin
         logic [ADDR_W-1:0] ra;
         logic [ADDR_W-1:0] rs0;
         logic [ADDR_W-1:0] rs1;
         ra  = rnd_addr();
         rs0 = rnd_addr();
         rs1 = rnd_addr();
         do_slot(ra, 1'($urandom_range(0, 1)), rand_line(),
                 int'($urandom_range(0, 2)), rs0, rs1);
      end
      do_slot(9'd1, 1'b0, rand_line(), 0, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
